// File: rtl/uart_dbg_cmd_engine.sv
// Debug command engine: parses host bytes from UART_RX into CPU halt/resume and
// single/burst memory accesses, returning read data through UART_TX.
module uart_dbg_cmd_engine #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter bit HALT_ON_RESET  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic              cpu_halt,
  output logic              busy,
  output logic              err_pulse,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_WDATA, S_BUS_WR, S_BUS_RD, S_TX_SEND, S_TX_WAIT
  } state_t;

  localparam int ABYTES = ADDR_W / 8;
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [7:0]          txd_q, txd_d;
  logic [7:0]          idx_q, idx_d;
  logic [8:0]          cnt_q, cnt_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                is_wr_q, is_wr_d;
  logic                burst_q, burst_d;
  logic                fixed_q, fixed_d;
  logic                we_q, we_d, re_q, re_d;
  logic                tx_start_q, tx_start_d;
  logic                halt_q, halt_d;
  logic                err_q, err_d;
  logic                in_cmd;

  // Bus handshake: mem_we/mem_re rise the cycle after entering BUS_WR/BUS_RD and
  // stay high, with mem_addr/mem_wdata frozen, until the cycle mem_ready is seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      txd_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      is_wr_q    <= 1'b0;
      burst_q    <= 1'b0;
      fixed_q    <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      tx_start_q <= 1'b0;
      halt_q     <= HALT_ON_RESET;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      txd_q      <= txd_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      is_wr_q    <= is_wr_d;
      burst_q    <= burst_d;
      fixed_q    <= fixed_d;
      we_q       <= we_d;
      re_q       <= re_d;
      tx_start_q <= tx_start_d;
      halt_q     <= halt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    txd_d      = txd_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    is_wr_d    = is_wr_q;
    burst_d    = burst_q;
    fixed_d    = fixed_q;
    we_d       = we_q;
    re_d       = re_q;
    tx_start_d = 1'b0;
    halt_d     = halt_q;
    err_d      = 1'b0;
    in_cmd     = (state_q == S_ADDR) || (state_q == S_LEN) || (state_q == S_WDATA);
    tmo_d      = (in_cmd && !rx_valid) ? tmo_q + TW'(1) : '0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          case (rx_data[6:0])
            7'h00: halt_d = 1'b1;
            7'h01: halt_d = 1'b0;
            7'h02, 7'h03, 7'h04, 7'h05: begin
              is_wr_d = ~rx_data[0];
              burst_d = rx_data[2];
              fixed_d = rx_data[7] & rx_data[2];
              cnt_d   = 9'd1;
              idx_d   = '0;
              state_d = S_ADDR;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          addr_d = (addr_q << 8) | ADDR_W'(rx_data);
          if (idx_q == 8'(ABYTES - 1))
            state_d = burst_q ? S_LEN : (is_wr_q ? S_WDATA : S_BUS_RD);
          else
            idx_d = idx_q + 8'd1;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          cnt_d   = {1'b0, rx_data} + 9'd1;
          state_d = is_wr_q ? S_WDATA : S_BUS_RD;
        end
      end
      S_WDATA: begin
        if (rx_valid) begin
          wdata_d = rx_data;
          state_d = S_BUS_WR;
        end
      end
      S_BUS_WR: begin
        if (!we_q) begin
          we_d = 1'b1;
        end else if (mem_ready) begin
          we_d    = 1'b0;
          addr_d  = fixed_q ? addr_q : addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - 9'd1;
          state_d = (cnt_q == 9'd1) ? S_IDLE : S_WDATA;
        end
      end
      S_BUS_RD: begin
        if (!re_q) begin
          re_d = 1'b1;
        end else if (mem_ready) begin
          re_d    = 1'b0;
          txd_d   = mem_rdata;
          addr_d  = fixed_q ? addr_q : addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - 9'd1;
          state_d = S_TX_SEND;
        end
      end
      S_TX_SEND: begin
        if (!tx_active) begin
          tx_start_d = 1'b1;
          state_d    = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (tx_done)
          state_d = (cnt_q != 9'd0) ? S_BUS_RD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A stalled host abandons the command before any bus access happens.
    if (in_cmd && !rx_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 1))) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      tmo_d   = '0;
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = txd_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign cpu_halt  = halt_q;
  assign busy      = (state_q != S_IDLE);
  assign err_pulse = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_dbg_cmd_engine.sv
// Bench for uart_dbg_cmd_engine: directed host commands, a bus responder and a
// UART_TX model that pop expected transactions from queues as the DUT emits them.
module tb_uart_dbg_cmd_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_active = 1'b0;
  logic        tx_done = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re;
  logic [7:0]  mem_rdata;
  logic        mem_ready = 1'b0;
  logic        cpu_halt, busy, err_pulse;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;

  // {we, re, addr, wdata}; reads carry wdata 00.
  logic [25:0] exp_bus_q[$];
  logic [7:0]  exp_tx_q[$];

  assign mem_rdata = mem_addr[7:0];

  uart_dbg_cmd_engine #(.ADDR_W(16), .TIMEOUT_CYCLES(40), .HALT_ON_RESET(1'b0)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_active(tx_active), .tx_done(tx_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .cpu_halt(cpu_halt), .busy(busy),
    .err_pulse(err_pulse), .dbg_state(dbg_state)
  );

  always #20 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
    exp_bus_q.push_back({1'b1, 1'b0, a, d});
  endtask

  task automatic push_rd(input logic [15:0] a);
    exp_bus_q.push_back({1'b0, 1'b1, a, 8'h00});
    exp_tx_q.push_back(a[7:0]);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((busy || exp_bus_q.size() != 0 || exp_tx_q.size() != 0) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, 32'(n < 10000), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk)
    if (rst && err_pulse) err_seen++;

  // Bus responder and monitor.
  initial begin
    logic [25:0] first, act;
    forever begin
      @(negedge clk);
      if (rst && (mem_we || mem_re)) begin
        first = {mem_we, mem_re, mem_addr, mem_we ? mem_wdata : 8'h00};
        repeat ($urandom_range(0, 3)) @(negedge clk);
        act = {mem_we, mem_re, mem_addr, mem_we ? mem_wdata : 8'h00};
        check("bus_stable", 32'(act), 32'(first));
        if (exp_bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got %h expected none", act);
        end else begin
          check("bus", 32'(act), 32'(exp_bus_q.pop_front()));
        end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
      end
    end
  end

  // UART_TX model and monitor.
  initial begin
    logic [7:0] sent;
    forever begin
      @(negedge clk);
      if (rst && tx_start) begin
        sent = tx_data;
        if (exp_tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got %h expected none", sent);
        end else begin
          check("tx_byte", 32'(sent), 32'(exp_tx_q.pop_front()));
        end
        tx_active = 1'b1;
        repeat (4) @(negedge clk);
        check("tx_held", 32'(tx_data), 32'(sent));
        tx_done   = 1'b1;
        tx_active = 1'b0;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  initial begin
    int e0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({tx_start, mem_we, mem_re, busy, err_pulse, cpu_halt, dbg_state}), 32'd0);
    check("reset_data", {tx_data, mem_addr, mem_wdata}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: reset mid-ADDR drops the command, then a clean single read
    send_byte(8'h03);
    send_byte(8'h20);
    check("mid_cmd_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_busy", 32'(busy), 32'd0);
    push_rd(16'h2002);
    send_byte(8'h03); send_byte(8'h20); send_byte(8'h02);
    wait_done("read_2002");

    // 2: single write
    push_wr(16'h2345, 8'hA5);
    send_byte(8'h02); send_byte(8'h23); send_byte(8'h45); send_byte(8'hA5);
    wait_done("write_2345");
    check("write_busy_after", 32'(busy), 32'd0);

    // 3: incrementing burst write, then fixed-address burst write
    push_wr(16'h0010, 8'h11); push_wr(16'h0011, 8'h22); push_wr(16'h0012, 8'h33);
    send_byte(8'h04); send_byte(8'h00); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    wait_done("bwrite_0010");
    push_wr(16'h2007, 8'hAA); push_wr(16'h2007, 8'hBB);
    send_byte(8'h84); send_byte(8'h20); send_byte(8'h07); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB);
    wait_done("bwrite_fixed");

    // 4: burst read across the address wrap
    push_rd(16'hFFFE); push_rd(16'hFFFF); push_rd(16'h0000);
    send_byte(8'h05); send_byte(8'hFF); send_byte(8'hFE); send_byte(8'h02);
    wait_done("bread_wrap");

    // 5: halt / bad opcode / resume; F bit ignored on halt
    e0 = err_seen;
    send_byte(8'h00);
    check("halt", 32'(cpu_halt), 32'd1);
    send_byte(8'h7E);
    check("bad_op_err", 32'(err_seen - e0), 32'd1);
    check("bad_op_halt", 32'(cpu_halt), 32'd1);
    check("bad_op_busy", 32'(busy), 32'd0);
    send_byte(8'h01);
    check("resume", 32'(cpu_halt), 32'd0);
    send_byte(8'h80);
    check("halt_fbit", 32'(cpu_halt), 32'd1);
    send_byte(8'h01);
    check("resume2", 32'(cpu_halt), 32'd0);

    // 6: timeout mid-ADDR, then a normal read
    e0 = err_seen;
    send_byte(8'h02); send_byte(8'h12);
    repeat (60) @(negedge clk);
    check("timeout_err", 32'(err_seen - e0), 32'd1);
    check("timeout_idle", 32'(busy), 32'd0);
    push_rd(16'h0000);
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
    wait_done("read_after_timeout");
    check("no_spurious_err", 32'(err_seen - e0), 32'd1);

    // 7: maximum-length fixed-address burst read (256 accesses)
    for (int i = 0; i < 256; i++) push_rd(16'h1234);
    send_byte(8'h85); send_byte(8'h12); send_byte(8'h34); send_byte(8'hFF);
    wait_done("bread_256");

    repeat (20) @(negedge clk);
    check("bus_q_empty", 32'(exp_bus_q.size()), 32'd0);
    check("tx_q_empty", 32'(exp_tx_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
